rx_frame_controller: RTL and testbench



---
 rtl/rx_frame_pkg.sv | 14 +
 rtl/rx_edge_strobe.sv | 23 ++
 rtl/rx_frame_controller.sv | 153 +++++++++++++++
 tb/tb_rx_frame_controller.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared constants and state encoding for the receive frame path.
// The command decoder imports RX_FRAME_BYTES from here so both sides agree on frame length.
package rx_frame_pkg;

    localparam int unsigned RX_FRAME_BYTES    = 3;
    localparam int unsigned RX_TIMEOUT_CYCLES = 100000;

    typedef logic [1:0] rxState_t;

    localparam rxState_t IDLE    = 2'd0;
    localparam rxState_t COLLECT = 2'd1;
    localparam rxState_t HOLD    = 2'd2;

endpackage

// File: rtl/rx_edge_strobe.sv
// Rising-edge detector for the receiver done level.
// The history register resets to 1 so a level already high at reset release is not a byte.
module rx_edge_strobe (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic strobe
);

    logic doneQ;

    // Remember the previous level; reset high to suppress a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            doneQ <= 1'b1;
        end else begin
            doneQ <= level;
        end
    end

    assign strobe = level & ~doneQ;

endmodule

// File: rtl/rx_frame_controller.sv
// Collects received bytes into fixed-length frames and offers each frame over valid/ready.
// Partial frames are dropped after an inter-byte timeout; bytes arriving while a frame is
// pending are dropped and reported.
module rx_frame_controller
    import rx_frame_pkg::*;
#(
    parameter int unsigned FRAME_BYTES    = RX_FRAME_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = RX_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     byte_done,
    input  logic [7:0]               byte_in,
    output logic [8*FRAME_BYTES-1:0] frame_out,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     timeout_err,
    output logic                     overflow_err,
    output logic                     busy
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned CountW = $clog2(FRAME_BYTES + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [CountW-1:0] CountLast = CountW'(FRAME_BYTES - 1);

    logic                     strobe;
    rxState_t                 stateQ, stateD;
    logic [CountW-1:0]        countQ, countD;
    logic [TimerW-1:0]        timerQ, timerD;
    logic [7:0]               slotQ    [FRAME_BYTES];
    logic [7:0]               slotNext [FRAME_BYTES];
    logic [8*FRAME_BYTES-1:0] frameD;
    logic                     writeEn;
    logic [CountW-1:0]        writeIdx;
    logic                     latchFrame;
    logic                     timeoutD;
    logic                     overflowD;

    rx_edge_strobe uEdge (
        .clk    (clk),
        .rst    (rst),
        .level  (byte_done),
        .strobe (strobe)
    );

    // Next-state logic: byte acceptance, inter-byte timer and pending-frame handshake.
    always_comb begin
        stateD     = stateQ;
        countD     = countQ;
        timerD     = timerQ;
        writeEn    = 1'b0;
        writeIdx   = '0;
        latchFrame = 1'b0;
        timeoutD   = 1'b0;
        overflowD  = 1'b0;
        case (stateQ)
            IDLE: begin
                timerD = '0;
                if (strobe) begin
                    writeEn = 1'b1;
                    countD  = CountW'(1);
                    stateD  = COLLECT;
                end
            end
            COLLECT: begin
                if (strobe) begin
                    // A byte on the timeout cycle still counts; it wins over the timeout.
                    writeEn  = 1'b1;
                    writeIdx = countQ;
                    countD   = countQ + CountW'(1);
                    timerD   = '0;
                    if (countQ == CountLast) begin
                        latchFrame = 1'b1;
                        countD     = '0;
                        stateD     = HOLD;
                    end
                end else if (timerQ == TimerLast) begin
                    countD   = '0;
                    timerD   = '0;
                    timeoutD = 1'b1;
                    stateD   = IDLE;
                end else begin
                    timerD = timerQ + TimerW'(1);
                end
            end
            HOLD: begin
                timerD = '0;
                if (frame_ready) begin
                    if (strobe) begin
                        // Byte on the handshake cycle starts the next frame.
                        writeEn = 1'b1;
                        countD  = CountW'(1);
                        stateD  = COLLECT;
                    end else begin
                        stateD = IDLE;
                    end
                end else if (strobe) begin
                    overflowD = 1'b1;
                end
            end
            default: begin
                stateD = IDLE;
                countD = '0;
                timerD = '0;
            end
        endcase
    end

    // Slot array with the incoming byte merged in, used both for storage and frame latch.
    always_comb begin
        for (int i = 0; i < FRAME_BYTES; i++) begin
            slotNext[i] = (writeEn && writeIdx == CountW'(i)) ? byte_in : slotQ[i];
        end
    end

    // First received byte lands in the most significant byte of the frame.
    for (genvar g = 0; g < FRAME_BYTES; g++) begin : gSlotMap
        assign frameD[8*(FRAME_BYTES-g)-1 -: 8] = slotNext[g];
    end

    // State, storage and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ       <= IDLE;
            countQ       <= '0;
            timerQ       <= '0;
            frame_out    <= '0;
            frame_valid  <= 1'b0;
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
            busy         <= 1'b0;
            for (int i = 0; i < FRAME_BYTES; i++) begin
                slotQ[i] <= '0;
            end
        end else begin
            stateQ       <= stateD;
            countQ       <= countD;
            timerQ       <= timerD;
            frame_valid  <= (stateD == HOLD);
            timeout_err  <= timeoutD;
            overflow_err <= overflowD;
            busy         <= (stateD != IDLE);
            if (latchFrame) begin
                frame_out <= frameD;
            end
            for (int i = 0; i < FRAME_BYTES; i++) begin
                slotQ[i] <= slotNext[i];
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_controller.sv
// Bench for rx_frame_controller: a 3-byte and a 4-byte instance share stimulus; completed
// frames are checked against a queue of expected frames at each handshake.
module tb_rx_frame_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        byteDone;
    logic [7:0]  byteIn;
    logic        frameReady;

    logic [23:0] frameOut3;
    logic        frameValid3, timeoutErr3, overflowErr3, busy3;
    logic [31:0] frameOut4;
    logic        frameValid4, timeoutErr4, overflowErr4, busy4;

    int errors = 0;
    int checks = 0;
    int ovfCount = 0;
    int toCount = 0;
    int base;
    bit en4 = 1'b0;

    logic [23:0] q3 [$];
    logic [31:0] q4 [$];
    logic [23:0] e3;
    logic [31:0] e4;

    typedef struct packed {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [23:0] exp;
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;

    rx_frame_controller #(.FRAME_BYTES(3), .TIMEOUT_CYCLES(16)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .byte_done    (byteDone),
        .byte_in      (byteIn),
        .frame_out    (frameOut3),
        .frame_valid  (frameValid3),
        .frame_ready  (frameReady),
        .timeout_err  (timeoutErr3),
        .overflow_err (overflowErr3),
        .busy         (busy3)
    );

    rx_frame_controller #(.FRAME_BYTES(4), .TIMEOUT_CYCLES(16)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .byte_done    (byteDone),
        .byte_in      (byteIn),
        .frame_out    (frameOut4),
        .frame_valid  (frameValid4),
        .frame_ready  (frameReady),
        .timeout_err  (timeoutErr4),
        .overflow_err (overflowErr4),
        .busy         (busy4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle done pulse followed by one low cycle.
    task automatic sendByte(input logic [7:0] b);
        byteIn   = b;
        byteDone = 1'b1;
        step();
        byteDone = 1'b0;
        step();
    endtask

    // Scoreboard and pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (frameValid3 === 1'b1 && frameReady === 1'b1) begin
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame3_unexpected: got %h, expected no frame", frameOut3);
            end else begin
                e3 = q3.pop_front();
                check("frame3", {8'h00, frameOut3}, {8'h00, e3});
            end
        end
        if (en4 && frameValid4 === 1'b1 && frameReady === 1'b1) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame4_unexpected: got %h, expected no frame", frameOut4);
            end else begin
                e4 = q4.pop_front();
                check("frame4", frameOut4, e4);
            end
        end
        if (overflowErr3 === 1'b1) ovfCount++;
        if (timeoutErr3 === 1'b1) toCount++;
    end

    initial begin
        vecs[0] = '{b0: 8'h01, b1: 8'h02, b2: 8'h03, exp: 24'h010203};
        vecs[1] = '{b0: 8'hFF, b1: 8'h00, b2: 8'h80, exp: 24'hFF0080};
        vecs[2] = '{b0: 8'h12, b1: 8'h34, b2: 8'h56, exp: 24'h123456};
        vecs[3] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, exp: 24'h000000};

        rst = 1'b1;
        byteDone = 1'b0;
        byteIn = 8'h00;
        frameReady = 1'b1;
        step();
        step();
        step();
        check("rst_frame_out", {8'h00, frameOut3}, 32'h0);
        check("rst_valid", {31'h0, frameValid3}, 32'h0);
        check("rst_timeout", {31'h0, timeoutErr3}, 32'h0);
        check("rst_overflow", {31'h0, overflowErr3}, 32'h0);
        check("rst_busy", {31'h0, busy3}, 32'h0);
        rst = 1'b0;
        step();

        // Basic frame: valid for exactly one cycle right after the last strobe.
        q3.push_back(24'hA53C0F);
        sendByte(8'hA5);
        check("basic_busy", {31'h0, busy3}, 32'h1);
        sendByte(8'h3C);
        byteIn = 8'h0F;
        byteDone = 1'b1;
        step();
        check("basic_valid_rise", {31'h0, frameValid3}, 32'h1);
        check("basic_frame", {8'h00, frameOut3}, 32'h00A53C0F);
        byteDone = 1'b0;
        step();
        check("basic_valid_fall", {31'h0, frameValid3}, 32'h0);
        check("basic_idle", {31'h0, busy3}, 32'h0);

        // Table of frames with the consumer always ready.
        for (int i = 0; i < 4; i++) begin
            q3.push_back(vecs[i].exp);
            sendByte(vecs[i].b0);
            sendByte(vecs[i].b1);
            sendByte(vecs[i].b2);
            step();
        end

        // Timeout after 16 idle edges, then a clean frame.
        base = toCount;
        sendByte(8'h11);
        sendByte(8'h22);
        for (int i = 0; i < 14; i++) step();
        check("to_not_early", {31'h0, timeoutErr3}, 32'h0);
        check("to_busy_before", {31'h0, busy3}, 32'h1);
        step();
        check("to_pulse", {31'h0, timeoutErr3}, 32'h1);
        check("to_busy_after", {31'h0, busy3}, 32'h0);
        step();
        check("to_pulse_end", {31'h0, timeoutErr3}, 32'h0);
        check("to_count", toCount - base, 1);
        q3.push_back(24'h334455);
        sendByte(8'h33);
        sendByte(8'h44);
        sendByte(8'h55);
        step();

        // Byte on the timeout cycle wins.
        base = toCount;
        sendByte(8'h11);
        for (int i = 0; i < 14; i++) step();
        byteIn = 8'h22;
        byteDone = 1'b1;
        step();
        check("tob_no_timeout", {31'h0, timeoutErr3}, 32'h0);
        check("tob_busy", {31'h0, busy3}, 32'h1);
        byteDone = 1'b0;
        step();
        q3.push_back(24'h112233);
        sendByte(8'h33);
        step();
        check("tob_count", toCount - base, 0);

        // Backpressure: bytes in HOLD are dropped and reported each time.
        base = ovfCount;
        frameReady = 1'b0;
        q3.push_back(24'h010203);
        sendByte(8'h01);
        sendByte(8'h02);
        sendByte(8'h03);
        step();
        check("bp_valid", {31'h0, frameValid3}, 32'h1);
        sendByte(8'h04);
        check("bp_ovf_once", ovfCount - base, 1);
        check("bp_frame_kept", {8'h00, frameOut3}, 32'h00010203);
        check("bp_valid_kept", {31'h0, frameValid3}, 32'h1);
        sendByte(8'h05);
        check("bp_ovf_twice", ovfCount - base, 2);
        frameReady = 1'b1;
        step();
        check("bp_release", {31'h0, frameValid3}, 32'h0);
        step();

        // Handshake and strobe in the same cycle.
        base = ovfCount;
        frameReady = 1'b0;
        q3.push_back(24'h0A0B0C);
        sendByte(8'h0A);
        sendByte(8'h0B);
        sendByte(8'h0C);
        step();
        byteIn = 8'hAA;
        byteDone = 1'b1;
        frameReady = 1'b1;
        step();
        check("sim_valid_fall", {31'h0, frameValid3}, 32'h0);
        check("sim_busy", {31'h0, busy3}, 32'h1);
        byteDone = 1'b0;
        step();
        q3.push_back(24'hAABBCC);
        sendByte(8'hBB);
        sendByte(8'hCC);
        step();
        check("sim_no_ovf", ovfCount - base, 0);

        // A long done level is one byte.
        byteIn = 8'h77;
        byteDone = 1'b1;
        step();
        byteIn = 8'h99;
        for (int i = 0; i < 9; i++) step();
        check("lvl_no_frame", {31'h0, frameValid3}, 32'h0);
        byteDone = 1'b0;
        step();
        q3.push_back(24'h778866);
        sendByte(8'h88);
        sendByte(8'h66);
        step();

        // Reset mid-frame with done held high across release.
        base = toCount + ovfCount;
        sendByte(8'h01);
        sendByte(8'h02);
        rst = 1'b1;
        byteDone = 1'b1;
        step();
        check("mr_frame_out", {8'h00, frameOut3}, 32'h0);
        check("mr_valid", {31'h0, frameValid3}, 32'h0);
        check("mr_busy", {31'h0, busy3}, 32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("mr_no_strobe", {31'h0, busy3}, 32'h0);
        byteDone = 1'b0;
        step();
        q3.push_back(24'h212223);
        sendByte(8'h21);
        sendByte(8'h22);
        sendByte(8'h23);
        step();
        check("mr_no_pulses", toCount + ovfCount - base, 0);

        // Four-byte instance.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        en4 = 1'b1;
        q3.push_back(24'hDEADBE);
        q4.push_back(32'hDEADBEEF);
        sendByte(8'hDE);
        sendByte(8'hAD);
        sendByte(8'hBE);
        check("fb4_not_yet", {31'h0, frameValid4}, 32'h0);
        byteIn = 8'hEF;
        byteDone = 1'b1;
        step();
        check("fb4_valid", {31'h0, frameValid4}, 32'h1);
        check("fb4_frame", frameOut4, 32'hDEADBEEF);
        byteDone = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        step();

        check("q3_drained", q3.size(), 0);
        check("q4_drained", q4.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
